// File: rtl/inverse_zigzag_buffer.sv
// -----------------------------------------------------------------------------
// inverse_zigzag_buffer
//
// Purpose:
//   Decoder-side stage feeding the dequantizer. Takes quantized coefficients
//   one per handshake in JPEG zigzag order and writes each one into its
//   row-major slot of an 8x8 block. When the block is complete, it is
//   presented in parallel. Two register banks work as a ping-pong pair, so
//   the next block can fill while the previous one is held for downstream.
//
// Parameters:
//   BLOCK_SIZE  - block dimension. Only 8 is supported; any other value
//                 stops elaboration.
//   COEFF_WIDTH - signed coefficient width. Must match the dequantizer.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   in_coeff is valid
//   in_ready   out  the current write bank can accept a coefficient
//   in_coeff   in   signed coefficient at zigzag index k
//   in_eob     in   (only with IZZ_EOB_EN) end of block: the accepted
//                   coefficient is written and the block closes at once
//   out_valid  out  out_block holds a complete block
//   out_ready  in   downstream consumes out_block this cycle
//   out_block  out  reordered block, indexed [row][col]; all zeros while
//                   out_valid is low
//
// Optional feature:
//   Define IZZ_EOB_EN to add the in_eob port and early block completion.
// -----------------------------------------------------------------------------
module inverse_zigzag_buffer #(
   parameter int BLOCK_SIZE  = 8,
   parameter int COEFF_WIDTH = 9
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
`ifdef IZZ_EOB_EN
   input  logic                          in_eob,
`endif
   output logic                          in_ready,
   input  logic signed [COEFF_WIDTH-1:0] in_coeff,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic signed [COEFF_WIDTH-1:0] out_block [BLOCK_SIZE-1:0][BLOCK_SIZE-1:0]
);

   localparam int NUM = BLOCK_SIZE * BLOCK_SIZE;

   generate
      if (BLOCK_SIZE != 8) begin : g_bad_block_size
         $error("inverse_zigzag_buffer: BLOCK_SIZE must be 8");
      end
   endgenerate

   // Zigzag index k -> row-major position (row*8 + col), standard JPEG order.
   localparam logic [5:0] ZZ_TABLE [64] = '{
       6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
       6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
       6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
       6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
       6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
       6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
       6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
       6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   logic signed [COEFF_WIDTH-1:0] bank0 [NUM];
   logic signed [COEFF_WIDTH-1:0] bank1 [NUM];

   logic       wr_sel;
   logic       rd_sel;
   logic [1:0] full;
   logic [5:0] k;

   logic       eob;
   logic       accept;
   logic       complete;
   logic       release_blk;
   logic [5:0] zz_idx;
   logic [1:0] full_next;

`ifdef IZZ_EOB_EN
   assign eob = in_eob;
`else
   assign eob = 1'b0;
`endif

   assign in_ready    = !full[wr_sel];
   assign out_valid   = full[rd_sel];
   assign accept      = in_valid && in_ready;
   assign complete    = accept && ((k == 6'd63) || eob);
   assign release_blk = out_valid && out_ready;
   assign zz_idx      = ZZ_TABLE[k];

   // Completion and release always refer to different banks: completion
   // needs an empty write bank, release needs a full read bank. Both can
   // therefore be applied in the same cycle without conflict.
   always_comb begin
      full_next = full;
      if (complete) begin
         full_next[wr_sel] = 1'b1;
      end
      if (release_blk) begin
         full_next[rd_sel] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_sel <= 1'b0;
         rd_sel <= 1'b0;
         full   <= 2'b00;
         k      <= 6'd0;
      end else begin
         full <= full_next;
         if (release_blk) begin
            rd_sel <= !rd_sel;
         end
         if (complete) begin
            wr_sel <= !wr_sel;
            k      <= 6'd0;
         end else if (accept) begin
            k <= k + 6'd1;
         end
      end
   end

   // A released bank is wiped, so that a block closed early by in_eob reads
   // zeros in every position it never wrote.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM; i++) begin
            bank0[i] <= '0;
            bank1[i] <= '0;
         end
      end else begin
         if (release_blk) begin
            for (int i = 0; i < NUM; i++) begin
               if (rd_sel) begin
                  bank1[i] <= '0;
               end else begin
                  bank0[i] <= '0;
               end
            end
         end
         if (accept) begin
            if (wr_sel) begin
               bank1[zz_idx] <= in_coeff;
            end else begin
               bank0[zz_idx] <= in_coeff;
            end
         end
      end
   end

   // Parallel output, gated to zero while no complete block is held.
   genvar gi, gj;
   generate
      for (gi = 0; gi < BLOCK_SIZE; gi++) begin : g_row
         for (gj = 0; gj < BLOCK_SIZE; gj++) begin : g_col
            assign out_block[gi][gj] = !out_valid ? '0 :
                                       (rd_sel ? bank1[gi*BLOCK_SIZE+gj]
                                               : bank0[gi*BLOCK_SIZE+gj]);
         end
      end
   endgenerate

endmodule

// File: doc/inverse_zigzag_buffer.md
Name: inverse_zigzag_buffer

Overview:
- Decoder-side stage directly upstream of the dequantizer.
- Accepts a serial stream of quantized coefficients in JPEG zigzag order, one per handshake.
- Reorders them into a row-major 8x8 block and presents the whole block in parallel, as the 2-D signed array the dequantizer consumes.
- Ping-pong double-buffered, so the next block fills while the current one is held for downstream.

Parameters:
- BLOCK_SIZE, 8, block dimension; only 8 is supported, and elaboration must fail for any other value.
- COEFF_WIDTH, 9, signed coefficient width; must match the dequantizer's COEFF_WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  in_coeff is valid.
- in_ready  output  1  block can accept a coefficient this cycle.
- in_coeff  input  signed COEFF_WIDTH  coefficient at zigzag index k.
- out_valid  output  1  out_block holds a complete block.
- out_ready  input  1  downstream consumes out_block this cycle.
- out_block  output  signed COEFF_WIDTH, unpacked [BLOCK_SIZE-1:0][BLOCK_SIZE-1:0]  reordered block, indexed [row][col].

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is synchronous, active-low.
- Storage: two banks (B0, B1) of 64 x COEFF_WIDTH signed registers.
- State registers: wr_sel, rd_sel (1 bit each), full[1:0], and a 6-bit write index k.
- Reset (rst_n=0 at a clk edge):
  - wr_sel=rd_sel=0, full=0, k=0.
  - All bank entries cleared to 0.
  - Outputs: in_ready=1, out_valid=0, out_block all 0.
  - A partially received block is discarded, even if reset arrives mid-block.
- Input handshake:
  - in_ready = !full[wr_sel].
  - Accept when in_valid && in_ready: write in_coeff to bank[wr_sel] at (row,col)=ZZ(k), then k <= k+1.
- Zigzag map ZZ(k) is the standard JPEG order:
  - k0 (0,0), k1 (0,1), k2 (1,0), k3 (2,0), k4 (1,1), k5 (0,2), k6 (0,3), k7 (1,2), k8 (2,1), k9 (3,0) … k62 (7,6), k63 (7,7).
  - Implemented as a constant table; no arithmetic on coefficient values.
- Block complete: on the accept with k=63:
  - full[wr_sel] <= 1, wr_sel toggles, k wraps to 0.
- Output:
  - out_valid = full[rd_sel].
  - out_block = bank[rd_sel] when out_valid=1, otherwise all zeros.
  - Latency: 64th coefficient accepted at edge N, so out_valid=1 in the cycle after edge N.
- Release: on out_valid && out_ready:
  - full[rd_sel] <= 0, rd_sel toggles.
  - All 64 entries of the released bank are cleared to 0 at the same edge.
- Stability: out_block must hold stable while out_valid=1 and out_ready=0.
- Simultaneous events: fill-completion of one bank and release of the other at the same edge are both honoured.
  - Writing into the bank being released cannot happen, because in_ready=0 for a full bank.
- Both banks full: in_ready=0 until a release. in_ready rises in the cycle after the release edge, so no combinational in_ready/out_ready path.
- Throughput: continuous 1 coeff/cycle with no input stalls, provided downstream releases each block within 64 cycles.
- Ordering: blocks emerge strictly in arrival order.
- Values: signed values pass through bit-exact, with no width change or saturation.

Optional Feature:
- Macro IZZ_EOB_EN.
- Defined:
  - Adds input port in_eob (1 bit, qualified by in_valid && in_ready).
  - An accepted coefficient with in_eob=1 is written normally and completes the block immediately: full set, wr_sel toggles, k <= 0.
  - Remaining positions stay 0, guaranteed by the clear-on-release rule.
  - in_eob with k=63 behaves identically to a normal completion.
- Not defined: port in_eob absent; a block completes only at k=63.

Test Plan:
- Reset, then stream 64 coefficients with value k+1, in_valid=1 continuously, out_ready=1 -> out_valid=1 one cycle after the 64th accept, with out_block[0][0]=1, [0][1]=2, [1][0]=3, [2][0]=4, [7][6]=63, [7][7]=64; out_valid drops the cycle after.
- out_ready=0; send block A (all 5), block B (all -7), then begin block C -> in_ready=0 after 128 accepts and out_block holds A stable. Raise out_ready -> A, then B, then C, in order, with no data loss.
- Random in_valid bubbles (~50%) plus random out_ready, 10 blocks of random signed values -> output matches the software inverse-zigzag reference exactly.
- Extremes: coefficients -256 and +255 at k=0 and k=63 -> out_block[0][0]=-256, [7][7]=+255, sign intact.
- Reset asserted after 30 coefficients accepted -> out_valid=0, in_ready=1. Next full block of value 9 outputs all 9s with no stale data.
- IZZ_EOB_EN defined: send a full block of all 3s (released), then values 4, 5, 6 with in_eob on the third -> out_block [0][0]=4, [0][1]=5, [1][0]=6, all other 61 entries 0.
